mmio_hub: RTL and testbench

MMIO_HUB -- requirements
Module: mmio_hub

---
 rtl/mmio_hub_pkg.sv | 51 +++++
 rtl/mmio_hub_kbd_fifo.sv | 47 ++++
 rtl/mmio_hub.sv | 211 +++++++++++++++++++++
 tb/tb_mmio_hub.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_hub_pkg.sv
// Shared types, default internal register addresses and the region decoder
// used by the MMIO hub.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // What kind of target an accepted request addresses.
  typedef enum logic [2:0] {
    AK_UNMAP,
    AK_SLV,
    AK_KEY,
    AK_KEY_EN,
    AK_AUDIO
  } acc_e;

  localparam logic [31:0] KEY_ADDR_DEF    = 32'h0000_F000;
  localparam logic [31:0] KEY_EN_ADDR_DEF = KEY_ADDR_DEF + 32'd4;
  localparam logic [31:0] AUDIO_ADDR_DEF  = KEY_ADDR_DEF + 32'd8;

  // Region tables are zero-padded to this many entries before decoding.
  localparam int MAX_SLV = 16;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } dec_t;

  // Lowest-index region with base <= addr < base+size wins. The upper bound
  // is tested as (addr - base) < size so a region reaching the top of the
  // 32-bit space does not overflow.
  function automatic dec_t region_decode(input logic [31:0]          addr,
                                         input logic [MAX_SLV*32-1:0] base,
                                         input logic [MAX_SLV*32-1:0] size,
                                         input int                    n);
    dec_t r;
    r = '0;
    for (int i = MAX_SLV - 1; i >= 0; i--) begin
      if (i < n && addr >= base[i*32 +: 32] &&
          (addr - base[i*32 +: 32]) < size[i*32 +: 32]) begin
        r.hit = 1'b1;
        r.idx = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_hub_kbd_fifo.sv
// Keyboard byte FIFO. Pointers carry one extra wrap bit for full/empty.
// A push into a full FIFO succeeds when a pop happens in the same cycle;
// otherwise the byte is dropped and drop_o pulses.
module kbd_fifo #(
  parameter int KBD_DEPTH = 8,
  parameter int W         = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         drop_o
);
  localparam int AW = $clog2(KBD_DEPTH);

  logic [W-1:0] mem_q [KBD_DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // Pointer advance; wraps naturally modulo 2*KBD_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage write; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mmio_hub.sv
// MMIO hub: decodes CPU requests onto slave regions or the internal
// keyboard/audio registers and returns a one-cycle ready response.
//
// state   | meaning
// IDLE    | waiting for cpu_ce; latches the request when it arrives
// WAIT    | slave read in flight, counting down the read latency
// RESP    | cpu_ready high for one cycle with rdata/err
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int                   NUM_SLV     = 4,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE   = {32'h0008_0000, 32'h0004_0000, 32'h0002_0000, 32'h0001_0000},
  parameter logic [NUM_SLV*32-1:0] SLV_SIZE   = {32'hFFF8_0000, 32'h0004_0000, 32'h0002_0000, 32'h0001_0000},
  parameter int                   RD_LAT      = 1,
  parameter int                   KBD_DEPTH   = 8,
  parameter logic [31:0]          KEY_ADDR    = KEY_ADDR_DEF,
  parameter logic [31:0]          KEY_EN_ADDR = KEY_ADDR + 32'd4,
  parameter logic [31:0]          AUDIO_ADDR  = KEY_ADDR + 32'd8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_ce,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [3:0]            cpu_sel,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_err,
  output logic [NUM_SLV-1:0]    slv_ce,
  output logic [NUM_SLV-1:0]    slv_we,
  output logic [31:0]           slv_addr,
  output logic [3:0]            slv_sel,
  output logic [31:0]           slv_wdata,
  input  logic [NUM_SLV*32-1:0] slv_rdata,
  input  logic [7:0]            kb_ascii,
  input  logic                  kb_valid,
  output logic                  audio_en,
  output logic                  kb_overflow
);
  localparam int PADW = MAX_SLV * 32;
  localparam logic [PADW-1:0] BASE_PAD = PADW'(SLV_BASE);
  localparam logic [PADW-1:0] SIZE_PAD = PADW'(SLV_SIZE);

  state_e             state_q;
  logic [1:0]         cnt_q;
  logic [3:0]         idx_q;
  logic [NUM_SLV-1:0] slv_ce_q, slv_we_q;
  logic [31:0]        slv_addr_q, slv_wdata_q, rdata_q;
  logic [3:0]         slv_sel_q;
  logic               ready_q, err_q;
  logic               key_pop_q, aud_wr_q, aud_val_q, ken_wr_q;
  logic               audio_q, ovf_q, ovf_d;

  dec_t               dec;
  acc_e               kind_d;
  logic [31:0]        slv_off;
  logic [NUM_SLV-1:0] hit_oh;
  logic [31:0]        slv_rdata_sel;
  logic [7:0]         kb_head;
  logic               kb_empty, kb_full, kb_drop, kb_pop;

  // Address decode of the live request; internal registers win over regions.
  always_comb begin
    dec     = region_decode(cpu_addr, BASE_PAD, SIZE_PAD, NUM_SLV);
    slv_off = cpu_addr - BASE_PAD[32*dec.idx +: 32];
    hit_oh  = NUM_SLV'(1) << dec.idx;
    if (cpu_addr == KEY_ADDR)         kind_d = AK_KEY;
    else if (cpu_addr == KEY_EN_ADDR) kind_d = AK_KEY_EN;
    else if (cpu_addr == AUDIO_ADDR)  kind_d = AK_AUDIO;
    else if (dec.hit)                 kind_d = AK_SLV;
    else                              kind_d = AK_UNMAP;
  end

  // Read-data mux for the region latched at acceptance.
  always_comb begin
    slv_rdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == 4'(i)) slv_rdata_sel = slv_rdata[i*32 +: 32];
    end
  end

  // Request FSM with registered slave strobes and CPU response.
  // KEY reads snapshot the head byte and empty flag at acceptance, so a
  // push landing later cannot turn an empty-read into a spurious pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      slv_ce_q    <= '0;
      slv_we_q    <= '0;
      slv_addr_q  <= '0;
      slv_sel_q   <= '0;
      slv_wdata_q <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      key_pop_q   <= 1'b0;
      aud_wr_q    <= 1'b0;
      aud_val_q   <= 1'b0;
      ken_wr_q    <= 1'b0;
      audio_q     <= 1'b0;
    end else begin
      slv_ce_q <= '0;
      slv_we_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_ce) begin
            slv_sel_q   <= cpu_sel;
            slv_wdata_q <= cpu_wdata;
            aud_wr_q    <= (kind_d == AK_AUDIO) && cpu_we && cpu_sel[0];
            aud_val_q   <= cpu_wdata[0];
            ken_wr_q    <= (kind_d == AK_KEY_EN) && cpu_we;
            key_pop_q   <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= ST_RESP;
            case (kind_d)
              AK_SLV: begin
                idx_q      <= dec.idx;
                slv_addr_q <= slv_off;
                slv_ce_q   <= hit_oh;
                slv_we_q   <= cpu_we ? hit_oh : '0;
                if (!cpu_we) begin
                  ready_q <= 1'b0;
                  cnt_q   <= 2'(RD_LAT - 1);
                  state_q <= ST_WAIT;
                end
              end
              AK_KEY: begin
                if (!cpu_we && !kb_empty) begin
                  rdata_q   <= {4{kb_head}};
                  key_pop_q <= 1'b1;
                end
              end
              AK_KEY_EN: if (!cpu_we) rdata_q <= {31'b0, !kb_empty};
              AK_AUDIO:  if (!cpu_we) rdata_q <= {31'b0, audio_q};
              default:   err_q <= 1'b1;
            endcase
          end
        end
        ST_WAIT: begin
          if (cnt_q == 2'd0) begin
            rdata_q <= slv_rdata_sel;
            ready_q <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ST_RESP: begin
          ready_q   <= 1'b0;
          rdata_q   <= '0;
          err_q     <= 1'b0;
          key_pop_q <= 1'b0;
          aud_wr_q  <= 1'b0;
          ken_wr_q  <= 1'b0;
          if (aud_wr_q) audio_q <= aud_val_q;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign kb_pop = (state_q == ST_RESP) && key_pop_q;

  // Sticky overflow; a fresh drop wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == ST_RESP) && ken_wr_q) ovf_d = 1'b0;
    if (kb_drop) ovf_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  kbd_fifo #(
    .KBD_DEPTH(KBD_DEPTH),
    .W        (8)
  ) u_kbd_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (kb_valid),
    .data_i (kb_ascii),
    .pop_i  (kb_pop),
    .data_o (kb_head),
    .empty_o(kb_empty),
    .full_o (kb_full),
    .drop_o (kb_drop)
  );

  // Response is masked while rst is high so an aborted RESP never shows ready.
  assign cpu_ready   = ready_q & ~rst;
  assign cpu_err     = err_q & ~rst;
  assign cpu_rdata   = rst ? '0 : rdata_q;
  assign slv_ce      = slv_ce_q;
  assign slv_we      = slv_we_q;
  assign slv_addr    = slv_addr_q;
  assign slv_sel     = slv_sel_q;
  assign slv_wdata   = slv_wdata_q;
  assign audio_en    = audio_q;
  assign kb_overflow = ovf_q;

  logic unused_full;
  assign unused_full = kb_full;

endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub (RD_LAT=2, default map).
module tb_mmio_hub;

  localparam int DEPTH = 8;
  localparam logic [31:0] KEY   = 32'h0000_F000;
  localparam logic [31:0] KEYEN = 32'h0000_F004;
  localparam logic [31:0] AUD   = 32'h0000_F008;
  localparam logic [31:0] BASE [4] = '{32'h0001_0000, 32'h0002_0000, 32'h0004_0000, 32'h0008_0000};
  localparam logic [31:0] SIZE [4] = '{32'h0001_0000, 32'h0002_0000, 32'h0004_0000, 32'hFFF8_0000};

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_ce, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]   cpu_sel;
  logic         cpu_ready, cpu_err;
  logic [3:0]   slv_ce, slv_we, slv_sel;
  logic [31:0]  slv_addr, slv_wdata;
  logic [127:0] slv_rdata;
  logic [7:0]   kb_ascii;
  logic         kb_valid;
  logic         audio_en, kb_overflow;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  logic [7:0]  kq[$];
  logic        m_ovf;
  logic        m_audio;
  logic [31:0] sd [4];

  // Scratch results from access()
  logic [31:0] r_rd, r_addr, r_wd;
  logic        r_er, r_leak;
  logic [3:0]  r_ce, r_we, r_sel;
  int          r_lat, r_cen;

  always #5 clk = ~clk;

  mmio_hub #(.RD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_sel(cpu_sel), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .slv_ce(slv_ce), .slv_we(slv_we), .slv_addr(slv_addr), .slv_sel(slv_sel), .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata), .kb_ascii(kb_ascii), .kb_valid(kb_valid),
    .audio_en(audio_en), .kb_overflow(kb_overflow)
  );

  function automatic int model_decode(input logic [31:0] a);
    longint unsigned aa, b, e;
    aa = {32'h0, a};
    for (int i = 0; i < 4; i++) begin
      b = {32'h0, BASE[i]};
      e = b + {32'h0, SIZE[i]};
      if (aa >= b && aa < e) return i;
    end
    return -1;
  endfunction

  // Keyboard model: pop (if any) happens before push in the same cycle.
  function automatic logic [31:0] model_key_read(input logic push, input logic [7:0] b);
    logic [31:0] r;
    r = 32'h0;
    if (kq.size() != 0) r = {4{kq.pop_front()}};
    if (push) begin
      if (kq.size() < DEPTH) kq.push_back(b);
      else m_ovf = 1'b1;
    end
    return r;
  endfunction

  task automatic apply_slv_data();
    slv_rdata = {sd[3], sd[2], sd[1], sd[0]};
  endtask

  task automatic push_key(input logic [7:0] b);
    @(negedge clk);
    kb_valid = 1'b1;
    kb_ascii = b;
    @(negedge clk);
    kb_valid = 1'b0;
    if (kq.size() < DEPTH) kq.push_back(b);
    else m_ovf = 1'b1;
  endtask

  // One CPU transaction; optional keyboard push lands in the RESP cycle.
  task automatic access(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                        input logic [31:0] wd, input logic kb_resp, input logic [7:0] kb_b);
    @(negedge clk);
    cpu_ce = 1'b1; cpu_we = we; cpu_addr = addr; cpu_sel = sel; cpu_wdata = wd;
    r_rd = '0; r_er = 1'b0; r_lat = 0; r_ce = '0; r_we = '0; r_cen = 0;
    r_addr = '0; r_sel = '0; r_wd = '0; r_leak = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (slv_ce != 4'h0) begin
        r_ce |= slv_ce; r_we |= slv_we; r_cen++;
        r_addr = slv_addr; r_sel = slv_sel; r_wd = slv_wdata;
      end
      if (cpu_ready) begin
        r_lat = n; r_rd = cpu_rdata; r_er = cpu_err;
        break;
      end else if (cpu_rdata != 32'h0 || cpu_err) begin
        r_leak = 1'b1;
      end
    end
    cpu_ce = 1'b0;
    if (kb_resp && r_lat != 0) begin
      kb_valid = 1'b1; kb_ascii = kb_b;
    end
    @(negedge clk);
    kb_valid = 1'b0;
    if (slv_ce != 4'h0) r_cen++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    kq.delete(); m_ovf = 1'b0; m_audio = 1'b0;
    n_chk++;
    if ({cpu_ready, cpu_err, cpu_rdata, slv_ce, slv_we, audio_en, kb_overflow} !== 43'h0)
      $display("FAIL reset_outputs: ready=%b err=%b rdata=%h ce=%b we=%b audio=%b ovf=%b, want all 0",
               cpu_ready, cpu_err, cpu_rdata, slv_ce, slv_we, audio_en, kb_overflow);
    else n_pass++;
    access(KEYEN, 1'b0, 4'hF, 32'h0, 1'b0, 8'h0);
    n_chk++;
    if (r_rd !== 32'h0 || r_lat != 1) $display("FAIL reset_fifo_empty: rdata=%h lat=%0d want 0/1", r_rd, r_lat);
    else n_pass++;
  endtask

  task automatic test_slave_read();
    sd[0] = 32'hDEAD_BEEF; sd[1] = $urandom; sd[2] = $urandom; sd[3] = $urandom;
    apply_slv_data();
    access(32'h0001_0010, 1'b0, 4'hF, 32'h0, 1'b0, 8'h0);
    n_chk++;
    if (r_lat != 3 || r_rd !== 32'hDEAD_BEEF || r_er !== 1'b0)
      $display("FAIL slave_read_resp: lat=%0d rdata=%h err=%b want 3/deadbeef/0", r_lat, r_rd, r_er);
    else n_pass++;
    n_chk++;
    if (r_ce !== 4'b0001 || r_we !== 4'b0000 || r_cen != 1 || r_addr !== 32'h10)
      $display("FAIL slave_read_strobe: ce=%b we=%b cycles=%0d addr=%h want 0001/0000/1/10", r_ce, r_we, r_cen, r_addr);
    else n_pass++;
  endtask

  task automatic test_unmapped();
    access(32'h0000_8000, 1'b0, 4'hF, 32'h0, 1'b0, 8'h0);
    n_chk++;
    if (r_lat != 1 || r_er !== 1'b1 || r_rd !== 32'h0 || r_ce !== 4'h0)
      $display("FAIL unmapped_read: lat=%0d err=%b rdata=%h ce=%b want 1/1/0/0", r_lat, r_er, r_rd, r_ce);
    else n_pass++;
    access(32'h0000_F00C, 1'b1, 4'hF, 32'h1, 1'b0, 8'h0);
    n_chk++;
    if (r_er !== 1'b1 || r_ce !== 4'h0 || audio_en !== m_audio)
      $display("FAIL unmapped_write: err=%b ce=%b audio=%b want 1/0/%b", r_er, r_ce, audio_en, m_audio);
    else n_pass++;
  endtask

  task automatic test_key_fifo();
    logic [31:0] exp;
    push_key(8'h41);
    push_key(8'h42);
    access(KEYEN, 1'b0, 4'hF, 32'h0, 1'b0, 8'h0);
    n_chk++;
    if (r_rd !== 32'h1) $display("FAIL keyen_nonempty: got %h want 1", r_rd);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      exp = model_key_read(1'b0, 8'h0);
      access(KEY, 1'b0, 4'hF, 32'h0, 1'b0, 8'h0);
      n_chk++;
      if (r_rd !== exp || r_lat != 1) $display("FAIL key_read%0d: got %h lat=%0d want %h lat=1", k, r_rd, r_lat, exp);
      else n_pass++;
    end
    n_chk++;
    if (exp !== 32'h4242_4242) $display("FAIL key_model_order: model %h want 42424242", exp);
    else n_pass++;
    access(KEYEN, 1'b0, 4'hF, 32'h0, 1'b0, 8'h0);
    n_chk++;
    if (r_rd !== 32'h0) $display("FAIL keyen_empty: got %h want 0", r_rd);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    logic [7:0]  nb;
    for (int k = 0; k < DEPTH + 1; k++) push_key(8'($urandom));
    n_chk++;
    if (kb_overflow !== m_ovf || m_ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", kb_overflow);
    else n_pass++;
    access(KEYEN, 1'b1, 4'hF, 32'h0, 1'b0, 8'h0);
    m_ovf = 1'b0;
    n_chk++;
    if (kb_overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", kb_overflow);
    else n_pass++;
    // Full FIFO: pop and push in the same cycle must not overflow.
    nb = 8'($urandom);
    exp = model_key_read(1'b1, nb);
    access(KEY, 1'b0, 4'hF, 32'h0, 1'b1, nb);
    n_chk++;
    if (r_rd !== exp || kb_overflow !== m_ovf)
      $display("FAIL full_push_pop: rdata=%h ovf=%b want %h/%b", r_rd, kb_overflow, exp, m_ovf);
    else n_pass++;
    for (int k = 0; k < DEPTH; k++) begin
      exp = model_key_read(1'b0, 8'h0);
      access(KEY, 1'b0, 4'hF, 32'h0, 1'b0, 8'h0);
      n_chk++;
      if (r_rd !== exp) $display("FAIL drain%0d: got %h want %h", k, r_rd, exp);
      else n_pass++;
    end
    access(KEY, 1'b0, 4'hF, 32'h0, 1'b0, 8'h0);
    n_chk++;
    if (r_rd !== 32'h0 || r_er !== 1'b0) $display("FAIL key_empty_read: rdata=%h err=%b want 0/0", r_rd, r_er);
    else n_pass++;
    // Empty FIFO: pop gets 0, pushed byte is kept.
    nb = 8'($urandom);
    exp = model_key_read(1'b1, nb);
    access(KEY, 1'b0, 4'hF, 32'h0, 1'b1, nb);
    n_chk++;
    if (r_rd !== exp) $display("FAIL empty_push_pop: got %h want %h", r_rd, exp);
    else n_pass++;
    exp = model_key_read(1'b0, 8'h0);
    access(KEY, 1'b0, 4'hF, 32'h0, 1'b0, 8'h0);
    n_chk++;
    if (r_rd !== exp || exp !== {4{nb}}) $display("FAIL empty_push_kept: got %h want %h", r_rd, {4{nb}});
    else n_pass++;
  endtask

  task automatic test_random();
    int          cls, idx;
    logic [31:0] a, d, exp_rd;
    logic        w, any_leak;
    logic [3:0]  s, exp_ce;
    any_leak = 1'b0;
    for (int k = 0; k < 4; k++) sd[k] = $urandom;
    apply_slv_data();
    for (int t = 0; t < 24; t++) begin
      cls = $urandom_range(0, 4);
      if (cls == 4) a = $urandom_range(0, 32'h0000_EFFF);
      else a = BASE[cls] + $urandom_range(0, SIZE[cls] - 1);
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom);
      d = $urandom;
      idx = model_decode(a);
      access(a, w, s, d, 1'b0, 8'h0);
      any_leak |= r_leak;
      if (idx >= 0) begin
        exp_ce = 4'(1 << idx);
        exp_rd = w ? 32'h0 : sd[idx];
        n_chk++;
        if (r_lat != (w ? 1 : 3) || r_rd !== exp_rd || r_er !== 1'b0)
          $display("FAIL rand_resp a=%h we=%b: lat=%0d rdata=%h err=%b want %0d/%h/0", a, w, r_lat, r_rd, r_er, w ? 1 : 3, exp_rd);
        else n_pass++;
        n_chk++;
        if (r_ce !== exp_ce || r_we !== (w ? exp_ce : 4'h0) || r_cen != 1)
          $display("FAIL rand_strobe a=%h: ce=%b we=%b cycles=%0d want %b/%b/1", a, r_ce, r_we, r_cen, exp_ce, w ? exp_ce : 4'h0);
        else n_pass++;
        n_chk++;
        if (r_addr !== a - BASE[idx] || r_sel !== s || (w && r_wd !== d))
          $display("FAIL rand_payload a=%h: addr=%h sel=%h wd=%h want %h/%h/%h", a, r_addr, r_sel, r_wd, a - BASE[idx], s, d);
        else n_pass++;
      end else begin
        n_chk++;
        if (r_lat != 1 || r_er !== 1'b1 || r_rd !== 32'h0 || r_ce !== 4'h0)
          $display("FAIL rand_unmapped a=%h: lat=%0d err=%b rdata=%h ce=%b want 1/1/0/0", a, r_lat, r_er, r_rd, r_ce);
        else n_pass++;
      end
    end
    n_chk++;
    if (any_leak !== 1'b0) $display("FAIL resp_idle_zero: rdata/err nonzero without ready (got 1 want 0)");
    else n_pass++;
  endtask

  task automatic test_audio_and_abort();
    int pulses;
    access(AUD, 1'b1, 4'h1, 32'h1, 1'b0, 8'h0);
    m_audio = 1'b1;
    n_chk++;
    if (audio_en !== m_audio) $display("FAIL audio_set: got %b want %b", audio_en, m_audio);
    else n_pass++;
    access(AUD, 1'b1, 4'hE, 32'h0, 1'b0, 8'h0);
    n_chk++;
    if (audio_en !== m_audio) $display("FAIL audio_sel_masked: got %b want %b", audio_en, m_audio);
    else n_pass++;
    access(AUD, 1'b0, 4'hF, 32'h0, 1'b0, 8'h0);
    n_chk++;
    if (r_rd !== {31'b0, m_audio}) $display("FAIL audio_read: got %h want %h", r_rd, {31'b0, m_audio});
    else n_pass++;
    push_key(8'h55);
    // Reset while a slave read sits in WAIT.
    @(negedge clk);
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0002_0004; cpu_sel = 4'hF;
    @(negedge clk);
    rst = 1'b1; cpu_ce = 1'b0;
    pulses = 0;
    if (cpu_ready) pulses++;
    @(negedge clk);
    if (cpu_ready) pulses++;
    rst = 1'b0;
    kq.delete(); m_ovf = 1'b0; m_audio = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (cpu_ready) pulses++;
    end
    n_chk++;
    if (pulses != 0) $display("FAIL abort_no_ready: pulses=%0d want 0", pulses);
    else n_pass++;
    n_chk++;
    if (audio_en !== m_audio || kb_overflow !== m_ovf) $display("FAIL abort_state: audio=%b ovf=%b want 0/0", audio_en, kb_overflow);
    else n_pass++;
    access(KEYEN, 1'b0, 4'hF, 32'h0, 1'b0, 8'h0);
    n_chk++;
    if (r_rd !== 32'h0) $display("FAIL abort_fifo_empty: got %h want 0", r_rd);
    else n_pass++;
    access(32'h0002_0004, 1'b0, 4'hF, 32'h0, 1'b0, 8'h0);
    n_chk++;
    if (r_lat != 3 || r_rd !== sd[1] || r_ce !== 4'b0010 || r_addr !== 32'h4)
      $display("FAIL after_abort_read: lat=%0d rdata=%h ce=%b addr=%h want 3/%h/0010/4", r_lat, r_rd, r_ce, r_addr, sd[1]);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_sel = '0; cpu_wdata = '0;
    kb_ascii = '0; kb_valid = 1'b0; slv_rdata = '0;
    test_reset();
    test_slave_read();
    test_unmapped();
    test_key_fifo();
    test_overflow();
    test_random();
    test_audio_and_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
